branch_pred_unit: RTL and testbench

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

---
 rtl/branch_pkg.sv | 32 +++
 rtl/branch_cmp.sv | 16 +
 rtl/branch_pred_unit.sv | 118 +++++++++++
 tb/tb_branch_pred_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolve/predict unit: funct3 conditions and
// the 2-bit PHT counter states with their saturating update.
package branch_pkg;

    localparam logic [2:0] F3_EQ   = 3'b000;
    localparam logic [2:0] F3_NE   = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_LT   = 3'b100;
    localparam logic [2:0] F3_GE   = 3'b101;
    localparam logic [2:0] F3_LTU  = 3'b110;
    localparam logic [2:0] F3_GEU  = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } pht_state_e;

    function automatic pht_state_e pht_next(input pht_state_e s, input logic taken);
        pht_state_e n;
        case (s)
            SNT:     n = taken ? WNT : SNT;
            WNT:     n = taken ? WT  : SNT;
            WT:      n = taken ? ST  : WNT;
            default: n = taken ? ST  : WT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Operand comparator: equality plus signed and unsigned less-than.
module branch_cmp #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            eq,
    output logic            lt_s,
    output logic            lt_u
);

    assign eq   = (a == b);
    assign lt_s = ($signed(a) < $signed(b));
    assign lt_u = (a < b);

endmodule

// File: rtl/branch_pred_unit.sv
// Branch resolve unit with a 2-bit PHT predictor, SLT/SLTU evaluation and a
// saturating mispredict counter. Registered results have one cycle of latency.
module branch_pred_unit
    import branch_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IDX_BITS = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_branch,
    input  logic             i_slt,
    input  logic [2:0]       i_funct3,
    input  logic [XLEN-1:0]  i_rs1,
    input  logic [XLEN-1:0]  i_rs2,
    input  logic [XLEN-1:0]  i_pc,
    input  logic             i_pred_taken,
    input  logic [XLEN-1:0]  i_lookup_pc,
    output logic             o_lookup_taken,
    output logic             o_valid,
    output logic             o_PCSrc,
    output logic             o_mispredict,
    output logic [XLEN-1:0]  o_slt_data,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    localparam int unsigned DEPTH = 2 ** IDX_BITS;

    logic                eq, lt_s, lt_u;
    logic                taken;
    logic                slt_bit;
    logic                acc_br;
    logic                acc_slt;
    logic                mispred;
    logic [IDX_BITS-1:0] wr_idx;
    logic [IDX_BITS-1:0] lk_idx;
    pht_state_e          lk_state;
    pht_state_e          pht [DEPTH];
    logic                unused_pc_bits;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .a    (i_rs1),
        .b    (i_rs2),
        .eq   (eq),
        .lt_s (lt_s),
        .lt_u (lt_u)
    );

    assign acc_br  = i_valid & i_branch & ~i_stall;
    assign acc_slt = i_valid & i_slt & ~i_branch & ~i_stall;
    assign mispred = acc_br & (taken != i_pred_taken);

    // funct3 010/011 are SLT encodings, so as branch conditions they resolve not-taken
    always_comb begin
        taken = 1'b0;
        case (i_funct3)
            F3_EQ:   taken = eq;
            F3_NE:   taken = ~eq;
            F3_LT:   taken = lt_s;
            F3_GE:   taken = ~lt_s;
            F3_LTU:  taken = lt_u;
            F3_GEU:  taken = ~lt_u;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        slt_bit = 1'b0;
        case (i_funct3)
            F3_SLT:  slt_bit = lt_s;
            F3_SLTU: slt_bit = lt_u;
            default: slt_bit = 1'b0;
        endcase
    end

    assign wr_idx         = i_pc[IDX_BITS+1:2];
    assign lk_idx         = i_lookup_pc[IDX_BITS+1:2];
    assign lk_state       = pht[lk_idx];
    assign o_lookup_taken = lk_state[1];

    assign unused_pc_bits = ^{i_pc[XLEN-1:IDX_BITS+2], i_pc[1:0],
                              i_lookup_pc[XLEN-1:IDX_BITS+2], i_lookup_pc[1:0]};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid       <= 1'b0;
            o_PCSrc       <= 1'b0;
            o_mispredict  <= 1'b0;
            o_slt_data    <= '0;
            o_mispred_cnt <= '0;
        end else if (!i_stall) begin
            o_valid      <= acc_br;
            o_PCSrc      <= acc_br & taken;
            o_mispredict <= mispred;
            o_slt_data   <= acc_slt ? XLEN'(slt_bit) : '0;
            if (mispred && (o_mispred_cnt != '1)) begin
                o_mispred_cnt <= o_mispred_cnt + CNT_W'(1);
            end
        end
    end

    // Lookup reads the array directly, so a same-cycle update is seen only next cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pht[i] <= WNT;
            end
        end else if (acc_br) begin
            pht[wr_idx] <= pht_next(pht[wr_idx], taken);
        end
    end

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: vector table plus hand sequences,
// with a scoreboard queue of expected registered results.
module tb_branch_pred_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, valid, stall, br, slt, pred;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, lpc;

    logic        o_lk, o_v, o_p, o_m;
    logic [31:0] o_slt;
    logic [15:0] o_cnt;
    logic        s_lk, s_v, s_p, s_m;
    logic [31:0] s_slt;
    logic [1:0]  s_cnt;

    branch_pred_unit #(.XLEN(32), .IDX_BITS(4), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall),
        .i_branch(br), .i_slt(slt), .i_funct3(f3), .i_rs1(rs1), .i_rs2(rs2),
        .i_pc(pc), .i_pred_taken(pred), .i_lookup_pc(lpc),
        .o_lookup_taken(o_lk), .o_valid(o_v), .o_PCSrc(o_p),
        .o_mispredict(o_m), .o_slt_data(o_slt), .o_mispred_cnt(o_cnt)
    );

    branch_pred_unit #(.XLEN(32), .IDX_BITS(4), .CNT_W(2)) dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall),
        .i_branch(br), .i_slt(slt), .i_funct3(f3), .i_rs1(rs1), .i_rs2(rs2),
        .i_pc(pc), .i_pred_taken(pred), .i_lookup_pc(lpc),
        .o_lookup_taken(s_lk), .o_valid(s_v), .o_PCSrc(s_p),
        .o_mispredict(s_m), .o_slt_data(s_slt), .o_mispred_cnt(s_cnt)
    );

    typedef struct {
        logic        valid, br, slt;
        logic [2:0]  f3;
        logic [31:0] a, b;
        logic        pred;
        logic        ev, ep, em;
        logic [31:0] es;
    } vec_t;

    typedef struct {
        logic        v, p, m;
        logic [31:0] slt;
        logic [15:0] cnt;
        logic [1:0]  cnt_s;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        sb[$];
    exp_t        last;
    logic [15:0] mcnt;
    logic [1:0]  mcnt_s;
    vec_t        tbl[14];

    function automatic vec_t mk(input logic v, input logic b, input logic s, input logic [2:0] f,
                                input logic [31:0] a, input logic [31:0] bb, input logic p,
                                input logic ev, input logic ep, input logic em, input logic [31:0] es);
        vec_t t;
        t.valid = v; t.br = b; t.slt = s; t.f3 = f; t.a = a; t.b = bb; t.pred = p;
        t.ev = ev; t.ep = ep; t.em = em; t.es = es;
        return t;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic st, input logic b, input logic s,
                         input logic [2:0] f, input logic [31:0] a, input logic [31:0] bb,
                         input logic [31:0] p_c, input logic p,
                         input logic ev, input logic ep, input logic em, input logic [31:0] es,
                         input logic [31:0] l_pc, input logic do_lk, input logic elk);
        exp_t e;
        @(negedge clk);
        rst = r; valid = v; stall = st; br = b; slt = s; f3 = f;
        rs1 = a; rs2 = bb; pc = p_c; pred = p; lpc = l_pc;
        if (r) begin
            mcnt = '0; mcnt_s = '0;
            e.v = 1'b0; e.p = 1'b0; e.m = 1'b0; e.slt = '0; e.cnt = '0; e.cnt_s = '0;
        end else if (st) begin
            e = last;
        end else begin
            if (em) begin
                if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                if (mcnt_s != 2'b11) mcnt_s = mcnt_s + 2'd1;
            end
            e.v = ev; e.p = ep; e.m = em; e.slt = es; e.cnt = mcnt; e.cnt_s = mcnt_s;
        end
        sb.push_back(e);
        #1;
        if (do_lk) begin
            chk("lookup_taken", 64'(o_lk), 64'(elk));
            chk("small_lookup_taken", 64'(s_lk), 64'(elk));
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        last = e;
        chk("o_valid", 64'(o_v), 64'(e.v));
        chk("o_PCSrc", 64'(o_p), 64'(e.p));
        chk("o_mispredict", 64'(o_m), 64'(e.m));
        chk("o_slt_data", 64'(o_slt), 64'(e.slt));
        chk("o_mispred_cnt", 64'(o_cnt), 64'(e.cnt));
        chk("small_o_valid", 64'(s_v), 64'(e.v));
        chk("small_o_PCSrc", 64'(s_p), 64'(e.p));
        chk("small_o_mispredict", 64'(s_m), 64'(e.m));
        chk("small_o_slt_data", 64'(s_slt), 64'(e.slt));
        chk("small_o_mispred_cnt", 64'(s_cnt), 64'(e.cnt_s));
    endtask

    initial begin
        //              v  br slt f3      rs1           rs2           pred ev ep em slt
        tbl[0]  = mk(1, 1, 0, 3'b100, 32'hFFFFFFFF, 32'h00000001, 0,   1, 1, 1, 0); // BLT -1<1
        tbl[1]  = mk(1, 1, 0, 3'b110, 32'hFFFFFFFF, 32'h00000001, 0,   1, 0, 0, 0); // BLTU
        tbl[2]  = mk(1, 1, 0, 3'b000, 32'd5,        32'd5,        1,   1, 1, 0, 0); // BEQ
        tbl[3]  = mk(1, 1, 0, 3'b001, 32'd5,        32'd5,        1,   1, 0, 1, 0); // BNE
        tbl[4]  = mk(1, 1, 0, 3'b101, 32'hFFFFFFFB, 32'd3,        0,   1, 0, 0, 0); // BGE -5>=3
        tbl[5]  = mk(1, 1, 0, 3'b111, 32'hFFFFFFFB, 32'd3,        0,   1, 1, 1, 0); // BGEU
        tbl[6]  = mk(1, 1, 0, 3'b010, 32'd1,        32'd2,        1,   1, 0, 1, 0); // f3 010 branch
        tbl[7]  = mk(1, 0, 1, 3'b010, 32'hFFFFFFFB, 32'd3,        0,   0, 0, 0, 1); // SLT
        tbl[8]  = mk(1, 0, 1, 3'b011, 32'hFFFFFFFB, 32'd3,        0,   0, 0, 0, 0); // SLTU
        tbl[9]  = mk(1, 1, 1, 3'b010, 32'hFFFFFFFB, 32'd3,        0,   1, 0, 0, 0); // both set
        tbl[10] = mk(1, 0, 1, 3'b000, 32'd1,        32'd2,        0,   0, 0, 0, 0); // SLT bad f3
        tbl[11] = mk(0, 1, 0, 3'b000, 32'd5,        32'd5,        0,   0, 0, 0, 0); // not valid
        tbl[12] = mk(1, 1, 0, 3'b110, 32'd1,        32'hFFFFFFFF, 1,   1, 1, 0, 0); // BLTU taken
        tbl[13] = mk(1, 0, 1, 3'b011, 32'd1,        32'd2,        0,   0, 0, 0, 1); // SLTU 1<2

        mcnt = '0; mcnt_s = '0;
        rst = 1'b1; valid = 1'b0; stall = 1'b0; br = 1'b0; slt = 1'b0; f3 = '0;
        rs1 = '0; rs2 = '0; pc = '0; pred = 1'b0; lpc = '0;

        // reset with a mispredicting branch presented: discarded
        cycle(1, 1, 0, 1, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 0,0,0,0, 32'h40, 0, 0);
        cycle(1, 1, 1, 1, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h40, 0, 0,0,0,0, 32'h40, 1, 0);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h1234, 1, 0);

        for (int i = 0; i < 14; i++) begin
            cycle(0, tbl[i].valid, 0, tbl[i].br, tbl[i].slt, tbl[i].f3, tbl[i].a, tbl[i].b,
                  32'h204, tbl[i].pred, tbl[i].ev, tbl[i].ep, tbl[i].em, tbl[i].es, 32'h0, 0, 0);
        end

        // stall holds outputs, counter and PHT
        cycle(0, 1, 0, 1, 0, 3'b000, 32'd5, 32'd5, 32'h204, 0, 1,1,1,0, 32'h0, 0, 0);
        cycle(0, 1, 1, 1, 0, 3'b000, 32'd5, 32'd5, 32'h208, 0, 0,0,0,0, 32'h208, 1, 0);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h208, 1, 0);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h204, 1, 1);

        // mid-run reset with a request in flight, PHT back to WNT
        cycle(1, 1, 0, 1, 0, 3'b000, 32'd5, 32'd5, 32'h204, 0, 0,0,0,0, 32'h0, 0, 0);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h204, 1, 0);

        // PHT training at 0x40 (index 0), no same-cycle bypass
        cycle(0, 1, 0, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 1, 1,1,0,0, 32'h40, 1, 0);
        cycle(0, 1, 0, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 1, 1,1,0,0, 32'h40, 1, 1);
        cycle(0, 1, 0, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 1, 1,1,0,0, 32'h40, 1, 1);
        cycle(0, 1, 0, 1, 0, 3'b000, 32'd7, 32'd7, 32'h40, 1, 1,1,0,0, 32'h80, 1, 1);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h80, 1, 1);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h44, 1, 0);
        cycle(0, 1, 0, 1, 0, 3'b001, 32'd7, 32'd7, 32'h40, 1, 1,0,1,0, 32'h40, 1, 1);
        cycle(0, 1, 0, 1, 0, 3'b001, 32'd7, 32'd7, 32'h40, 1, 1,0,1,0, 32'h40, 1, 1);
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h40, 1, 0);

        // more mispredicts: 2-bit counter saturates at 3
        for (int k = 0; k < 4; k++) begin
            cycle(0, 1, 0, 1, 0, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h30C, 0, 1,1,1,0, 32'h30C, 0, 0);
        end
        cycle(0, 0, 0, 0, 0, 3'b000, 32'd0, 32'd0, 32'h0, 0, 0,0,0,0, 32'h30C, 1, 1);

        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard: got %0d leftover entries expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
